// File: rtl/seq_div1.sv
// Iterative restoring divider: unsigned dividend / divisor -> quotient, remainder.
// Latency: DIVIDEND_W+1 cycles from start sample to done (1 cycle for divide by zero).
// Backpressure: none; start is ignored while busy, results held until next done.
module seq_div1 #(
  parameter int DIVIDEND_W = 18,
  parameter int DIVISOR_W  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  // Partial remainder carries one extra bit: T < 2*D can exceed DIVISOR_W bits.
  localparam int R_W   = DIVISOR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [DIVIDEND_W-1:0] q, q_step;
  logic [R_W-1:0]        r, r_step, t;
  logic [DIVISOR_W-1:0]  d;
  logic [CNT_W-1:0]      cnt;
  logic                  ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    t      = {r[DIVISOR_W-1:0], q[DIVIDEND_W-1]};
    // r's top bit is always clear between steps; folding it in keeps the
    // compare exact for any R value.
    ge     = r[DIVISOR_W] | (t >= {1'b0, d});
    r_step = ge ? (t - {1'b0, d}) : t;
    q_step = {q[DIVIDEND_W-2:0], ge};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      r         <= '0;
      d         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else begin
              q   <= dividend;
              d   <= divisor;
              r   <= '0;
              cnt <= CNT_W'(DIVIDEND_W - 1);
            end
          end
        end
        RUN: begin
          q   <= q_step;
          r   <= r_step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient  <= q_step;
            remainder <= r_step[DIVISOR_W-1:0];
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div1.sv
// Self-checking bench for seq_div1: directed cases, then randomized operands
// compared against an arithmetic reference (/ and %).
// Outputs are sampled 1 time unit after each rising edge.
module tb_seq_div1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] dividend;
  logic [14:0] divisor;
  logic        busy;
  logic        done;
  logic [17:0] quotient;
  logic [14:0] remainder;
  logic        div_zero;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  seq_div1 #(.DIVIDEND_W(18), .DIVISOR_W(15)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: plain integer division, with the divide-by-zero convention.
  task automatic model(input logic [17:0] a, input logic [14:0] b,
                       output logic [17:0] eq, output logic [14:0] er,
                       output logic edz, output int elat);
    if (b == 0) begin
      eq = 18'h3FFFF; er = 15'd0; edz = 1'b1; elat = 0;
    end else begin
      eq = 18'(a / b); er = 15'(a % b); edz = 1'b0; elat = 18;
    end
  endtask

  // Issue one request; returns edges counted after the sampling edge until done seen.
  task automatic run_op(input logic [17:0] a, input logic [14:0] b, output int n);
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [17:0] a,
                              input logic [14:0] b, input int n);
    logic [17:0] eq;
    logic [14:0] er;
    logic        edz;
    int          elat;
    model(a, b, eq, er, edz, elat);
    check({tag, "_latency"}, 40'(n), 40'(elat));
    check({tag, "_done"},    40'(done), 40'd1);
    check({tag, "_quot"},    40'(quotient), 40'(eq));
    check({tag, "_rem"},     40'(remainder), 40'(er));
    check({tag, "_dz"},      40'(div_zero), 40'(edz));
  endtask

  initial begin
    int          n;
    logic        seen_done;
    logic [17:0] a;
    logic [14:0] b;
    longint      recon;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_done", 40'(done), 40'd0);
    check("rst_dz",   40'(div_zero), 40'd0);
    check("rst_quot", 40'(quotient), 40'd0);
    check("rst_rem",  40'(remainder), 40'd0);
    rst = 1'b0;

    // Basic case and single-cycle done pulse.
    run_op(18'd12, 15'd4, n);
    check_result("d12_4", 18'd12, 15'd4, n);
    check("d12_4_busy_in_done", 40'(busy), 40'd1);
    @(posedge clk); #1;
    check("d12_4_done_pulse", 40'(done), 40'd0);
    check("d12_4_busy_after", 40'(busy), 40'd0);

    // Max operands and a small case, then boundary operands at full cadence.
    run_op(18'h3FFFF, 15'h7FFF, n);
    check_result("max", 18'h3FFFF, 15'h7FFF, n);
    run_op(18'd100, 15'd7, n);
    check_result("d100_7", 18'd100, 15'd7, n);
    run_op(18'h2AAAA, 15'd1, n);
    check_result("div1", 18'h2AAAA, 15'd1, n);
    run_op(18'd5, 15'd9, n);
    check_result("small", 18'd5, 15'd9, n);

    // Divide by zero, then a valid division clears div_zero.
    run_op(18'd123, 15'd0, n);
    check_result("dz", 18'd123, 15'd0, n);
    run_op(18'd100, 15'd7, n);
    check_result("after_dz", 18'd100, 15'd7, n);

    // Second start during RUN is ignored.
    @(posedge clk); #1;
    start = 1'b1; dividend = 18'd100; divisor = 15'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b1; dividend = 18'd50; divisor = 15'd5;
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_result("ignore_run", 18'd100, 15'd7, n);
    // Start raised during the DONE cycle is also ignored.
    start = 1'b1; dividend = 18'd50; divisor = 15'd5;
    @(posedge clk); #1;
    check("ignore_done_busy", 40'(busy), 40'd0);
    start = 1'b0;

    // Results held during a new RUN; reset mid-RUN aborts with no done.
    @(posedge clk); #1;
    start = 1'b1; dividend = 18'd200; divisor = 15'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("hold_quot", 40'(quotient), 40'd14);
    check("hold_rem",  40'(remainder), 40'd2);
    check("hold_busy", 40'(busy), 40'd1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 40'(busy), 40'd0);
    check("abort_quot", 40'(quotient), 40'd0);
    check("abort_rem",  40'(remainder), 40'd0);
    check("abort_dz",   40'(div_zero), 40'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      seen_done = seen_done | done;
      @(posedge clk); #1;
    end
    check("abort_no_done", 40'(seen_done), 40'd0);

    // Randomized operands; a quarter use tiny divisors to stress long quotients.
    for (int i = 0; i < 1000; i++) begin
      a = 18'($urandom_range(0, 18'h3FFFF));
      if (i % 4 == 0) b = 15'($urandom_range(1, 15));
      else            b = 15'($urandom_range(0, 15'h7FFF));
      run_op(a, b, n);
      check_result("rand", a, b, n);
      if (b != 0) begin
        recon = longint'(quotient) * longint'(b) + longint'(remainder);
        check("rand_invariant", 40'(recon), 40'(a));
        check("rand_rem_lt_div", 40'(remainder < b), 40'd1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
